// File: rtl/psychic5_romrq_arbiter.sv
// N-channel ROM fetch arbiter sharing one SDRAM read port. Each channel keeps
// a last-address data latch so repeated fetches of the same address are free.
module psychic5_romrq_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 17,
  parameter int DW      = 8,
  parameter int RR_MODE = 0
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_INITRST,
  input  logic              i_FLUSH,
  input  logic [NCH-1:0]    i_RQ_n,
  input  logic [NCH*AW-1:0] i_RQ_ADDR,
  output logic [NCH*DW-1:0] o_DATA,
  output logic [NCH-1:0]    o_READY,
  output logic [AW-1:0]     o_SDRAM_ADDR,
  output logic              o_SDRAM_RQ,
  input  logic              i_SDRAM_VALID,
  input  logic [DW-1:0]     i_SDRAM_DATA
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NCHU = NCH;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     laddr [NCH];
  logic [DW-1:0]     ldata [NCH];
  logic [NCH-1:0]    lvalid;
  logic [AW-1:0]     gaddr;
  logic [CW-1:0]     gch;
  logic [CW-1:0]     ptr;
  logic [NCH-1:0]    pend;
  logic [CW-1:0]     win;
  logic [CW-1:0]     cand;
  logic [AW-1:0]     win_addr;
  logic              win_found;
  logic              grant;
  int unsigned       rr_idx;

  always_comb begin
    o_READY = '0;
    o_DATA  = '0;
    for (int unsigned k = 0; k < NCHU; k++) begin
      o_READY[k]            = lvalid[k] && (laddr[k] == i_RQ_ADDR[k*AW +: AW]);
      o_DATA[k*DW +: DW]    = ldata[k];
    end
  end

  assign pend = ~i_RQ_n & ~o_READY;

  // Round-robin scans upward from the channel after the last grant, wrapping.
  always_comb begin
    win       = '0;
    win_addr  = '0;
    win_found = 1'b0;
    cand      = '0;
    rr_idx    = 0;
    for (int unsigned j = 0; j < NCHU; j++) begin
      if (RR_MODE == 0) begin
        rr_idx = j;
      end else begin
        rr_idx = 32'(ptr) + j + 1;
        if (rr_idx >= NCHU) rr_idx = rr_idx - NCHU;
      end
      cand = CW'(rr_idx);
      if (pend[cand] && !win_found) begin
        win_found = 1'b1;
        win       = cand;
        win_addr  = i_RQ_ADDR[32'(cand)*AW +: AW];
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (win_found) begin
          grant    = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (i_SDRAM_VALID) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) state <= ST_IDLE;
    else               state <= state_nx;
  end

  assign o_SDRAM_RQ   = (state == ST_ISSUE);
  assign o_SDRAM_ADDR = gaddr;

  // The fill write is ordered after the flush so it wins for the granted channel.
  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      for (int unsigned k = 0; k < NCHU; k++) begin
        laddr[k] <= '0;
        ldata[k] <= '0;
      end
      lvalid <= '0;
      gaddr  <= '0;
      gch    <= '0;
      ptr    <= CW'(NCH - 1);
    end else begin
      if (grant) begin
        gaddr <= win_addr;
        gch   <= win;
        ptr   <= win;
      end
      if (i_FLUSH) lvalid <= '0;
      if (state == ST_ISSUE && i_SDRAM_VALID) begin
        laddr[gch]  <= gaddr;
        ldata[gch]  <= i_SDRAM_DATA;
        lvalid[gch] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psychic5_romrq_arbiter.sv
// Bench for psychic5_romrq_arbiter: fixed and round-robin instances share request
// inputs, each with its own SDRAM responder, checked against a latch-level model.
module tb_psychic5_romrq_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush;
  logic [NCH-1:0]    rq_n;
  logic [NCH*AW-1:0] rq_addr;
  logic [1:0]        sd_valid;
  logic [DW-1:0]     sd_data [2];
  logic [NCH*DW-1:0] dout [2];
  logic [NCH-1:0]    rdy [2];
  logic [AW-1:0]     sa [2];
  logic [1:0]        srq;

  psychic5_romrq_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(0)) u_fix (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .i_FLUSH(flush),
    .i_RQ_n(rq_n), .i_RQ_ADDR(rq_addr),
    .o_DATA(dout[0]), .o_READY(rdy[0]),
    .o_SDRAM_ADDR(sa[0]), .o_SDRAM_RQ(srq[0]),
    .i_SDRAM_VALID(sd_valid[0]), .i_SDRAM_DATA(sd_data[0])
  );

  psychic5_romrq_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RR_MODE(1)) u_rr (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .i_FLUSH(flush),
    .i_RQ_n(rq_n), .i_RQ_ADDR(rq_addr),
    .o_DATA(dout[1]), .o_READY(rdy[1]),
    .o_SDRAM_ADDR(sa[1]), .o_SDRAM_RQ(srq[1]),
    .i_SDRAM_VALID(sd_valid[1]), .i_SDRAM_DATA(sd_data[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: per instance, a set of latches plus "which channel/address is in flight".
  logic [AW-1:0]  mla [2][NCH];
  logic [DW-1:0]  mld [2][NCH];
  logic [NCH-1:0] mlv [2];
  logic [1:0]     mbusy;
  int             mgch [2];
  logic [AW-1:0]  mga [2];
  int             mptr [2];
  int             mcnt [2];
  logic [NCH-1:0] m_pend;
  logic           m_gr;
  int             m_start, m_k;
  bit             auto_en = 1'b1;
  bit             chk_en  = 1'b0;

  function automatic logic mrdy(int i, int k);
    return mlv[i][k] && (mla[i][k] == rq_addr[k*AW +: AW]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_gr = 1'b0;
      if (rst) begin
        for (int k = 0; k < NCH; k++) begin
          mla[i][k] = '0;
          mld[i][k] = '0;
        end
        mlv[i]   = '0;
        mbusy[i] = 1'b0;
        mga[i]   = '0;
        mgch[i]  = 0;
        mptr[i]  = NCH - 1;
        mcnt[i]  = 0;
      end else begin
        for (int k = 0; k < NCH; k++) m_pend[k] = !rq_n[k] && !mrdy(i, k);
        if (flush) mlv[i] = '0;
        if (mbusy[i]) begin
          if (sd_valid[i]) begin
            mla[i][mgch[i]] = mga[i];
            mld[i][mgch[i]] = sd_data[i];
            mlv[i][mgch[i]] = 1'b1;
            mbusy[i] = 1'b0;
          end
        end else if (m_pend != '0) begin
          m_start = (i == 1) ? (mptr[i] + 1) % NCH : 0;
          for (int j = 0; j < NCH; j++) begin
            m_k = (m_start + j) % NCH;
            if (m_pend[m_k] && !m_gr) begin
              m_gr     = 1'b1;
              mgch[i]  = m_k;
              mga[i]   = rq_addr[m_k*AW +: AW];
              mptr[i]  = m_k;
              mbusy[i] = 1'b1;
            end
          end
        end
      end
      if (m_gr) mcnt[i] = 1;
      else if (mbusy[i]) mcnt[i] = mcnt[i] + 1;
    end
    #1;
    if (auto_en) begin
      for (int i = 0; i < 2; i++) begin
        sd_valid[i] = mbusy[i] && (mcnt[i] == LAT);
        sd_data[i]  = mga[i][7:0] ^ 8'h86;
      end
    end
  end

  logic [NCH-1:0]    e_rdy;
  logic [NCH*DW-1:0] e_dat;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < NCH; k++) begin
          e_rdy[k]         = mrdy(i, k);
          e_dat[k*DW +: DW] = mld[i][k];
        end
        chk($sformatf("model_ready_u%0d", i), rdy[i], e_rdy);
        chk($sformatf("model_data_u%0d", i), dout[i], e_dat);
        chk($sformatf("model_rq_u%0d", i), srq[i], mbusy[i]);
        chk($sformatf("model_addr_u%0d", i), sa[i], mga[i]);
      end
    end
  end

  logic prev_rq1 = 1'b0;
  int   q_ch [$];
  always @(negedge clk) begin
    if (srq[1] && !prev_rq1) q_ch.push_back(int'(sa[1][15:14]));
    prev_rq1 = srq[1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    rq_n    = '1;
    rq_addr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_rq(input int k, input logic [AW-1:0] a);
    rq_n[k] = 1'b0;
    rq_addr[k*AW +: AW] = a;
  endtask

  task automatic wait_ready(input int i, input int k, input int maxc);
    int n;
    n = 0;
    while (!mrdy(i, k) && n < maxc) begin
      tick();
      n++;
    end
    chk($sformatf("wait_u%0d_ch%0d", i, k), mrdy(i, k), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; rq_n = '1; rq_addr = '0;
    sd_valid = '0; sd_data[0] = '0; sd_data[1] = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_ready", rdy[0], 4'h0);
    chk("rst_data", dout[0], 32'h0);
    chk("rst_rq", srq[0], 1'b0);
    chk("rst_addr", sa[0], 17'h0);

    // Single miss then hits on the same address.
    set_rq(0, 17'h00123);
    tick();
    chk("t1_rq", srq[0], 1'b1);
    chk("t1_addr", sa[0], 17'h00123);
    n = 0;
    while (!rdy[0][0] && n < 10) begin
      tick();
      n++;
    end
    chk("t1_latency", n, LAT);
    chk("t1_data", dout[0][7:0], 8'hA5);
    chk("t1_ready", rdy[0][0], 1'b1);
    repeat (4) begin
      tick();
      chk("t1_hit_no_rq", srq[0], 1'b0);
    end

    // Fixed priority: channel 1 beats 3 and starves it while it keeps missing.
    do_reset();
    set_rq(1, 17'h00100);
    set_rq(3, 17'h00300);
    tick();
    chk("t2_first_addr", sa[0], 17'h00100);
    wait_ready(0, 1, 10);
    for (int r = 0; r < 3; r++) begin
      rq_addr[1*AW +: AW] = 17'h00101 + AW'(r);
      wait_ready(0, 1, 12);
      chk("t2_ch3_starved", rdy[0][3], 1'b0);
    end
    rq_n[1] = 1'b1;
    wait_ready(0, 3, 12);
    chk("t2_ch3_addr", sa[0], 17'h00300);
    chk("t2_ch3_data", dout[0][31:24], 8'h86);

    // Round-robin with all channels missing continuously.
    do_reset();
    q_ch.delete();
    for (int k = 0; k < NCH; k++) set_rq(k, AW'(k) << 14);
    n = 0;
    while (q_ch.size() < 5 && n < 80) begin
      tick();
      n++;
      for (int k = 0; k < NCH; k++)
        if (mrdy(1, k)) rq_addr[k*AW +: AW] = rq_addr[k*AW +: AW] + 17'd1;
    end
    chk("t3_grants", q_ch.size() >= 5, 1'b1);
    for (int j = 0; j < 5; j++)
      if (j < q_ch.size()) chk($sformatf("t3_rr_order%0d", j), q_ch[j], j % 4);

    // Address change while the fetch is in flight.
    do_reset();
    set_rq(0, 17'h00010);
    tick();
    rq_addr[0 +: AW] = 17'h00020;
    n = 0;
    while (!mlv[0][0] && n < 10) begin
      tick();
      n++;
    end
    chk("t4_stale_ready", rdy[0][0], 1'b0);
    chk("t4_stale_data", dout[0][7:0], 8'h96);
    tick();
    chk("t4_refetch_rq", srq[0], 1'b1);
    chk("t4_refetch_addr", sa[0], 17'h00020);
    wait_ready(0, 0, 10);
    chk("t4_new_data", dout[0][7:0], 8'hA6);

    // Flush coinciding with the fill of channel 1.
    do_reset();
    set_rq(0, 17'h00040);
    wait_ready(0, 0, 10);
    set_rq(1, 17'h00041);
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #2;
      if (sd_valid[0]) break;
      n++;
    end
    chk("t5_valid_seen", sd_valid[0], 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t5_ch0_flushed", rdy[0][0], 1'b0);
    chk("t5_ch1_kept", rdy[0][1], 1'b1);
    chk("t5_ch1_data", dout[0][15:8], 8'hC7);
    wait_ready(0, 0, 12);
    chk("t5_ch0_refetched", rdy[0][0], 1'b1);

    // Reset during ISSUE, then a late VALID.
    do_reset();
    auto_en = 1'b0;
    sd_valid = '0;
    set_rq(0, 17'h00055);
    tick();
    tick();
    chk("t6_in_flight", srq[0], 1'b1);
    rst = 1'b1;
    rq_n = '1;
    tick();
    rst = 1'b0;
    sd_valid = 2'b11;
    sd_data[0] = 8'h77;
    sd_data[1] = 8'h77;
    tick();
    sd_valid = '0;
    tick();
    chk("t6_rq", srq[0], 1'b0);
    chk("t6_ready", rdy[0], 4'h0);
    chk("t6_data", dout[0], 32'h0);
    chk("t6_rr_data", dout[1], 32'h0);
    auto_en = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
